// File: rtl/snoop_responder.sv
// snoop_responder: per-dcache responder for the two-cache snoopy bus.
// It latches a snoop, looks it up in the frame arrays, supplies a Modified
// block cache-to-cache on a read snoop, invalidates on an invalidate snoop,
// writes the new MSI state, and then drops cctrans to signal completion.
module snoop_responder #(
  parameter logic [31:0] BAD = 32'hBAD1BAD1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ccwait,
  input  logic        ccinv,
  input  logic [31:0] snoopy_addr,
  output logic        cctrans,
  output logic        snoop_dWEN,
  output logic [31:0] snoop_data,
  output logic [31:0] snoop_daddr,
  input  logic        snoop_dwait,
  output logic [31:0] lk_addr,
  input  logic        lk_hit,
  input  logic [1:0]  lk_state,
  input  logic [31:0] lk_data0,
  input  logic [31:0] lk_data1,
  output logic        st_we,
  output logic [1:0]  st_state,
  output logic        snoop_hold
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_SEND0, S_SEND1, S_UPDATE, S_DONE
  } st_t;

  localparam logic [1:0] MSI_I = 2'b00;
  localparam logic [1:0] MSI_S = 2'b01;
  localparam logic [1:0] MSI_M = 2'b10;

  st_t         state_q;
  logic [31:0] addr_q;
  logic        inv_q;
  logic [1:0]  nst_q;    // state to write during UPDATE

  // Encoding 11 falls out as invalid because only S and M are matched.
  logic valid_blk, m_blk, sending, accepted;
  assign valid_blk = lk_hit & ((lk_state == MSI_S) | (lk_state == MSI_M));
  assign m_blk     = lk_hit & (lk_state == MSI_M);
  assign sending   = (state_q == S_SEND0) | (state_q == S_SEND1);
  assign accepted  = ~snoop_dwait;

  // Snoop sequencing FSM; ccwait is only observed in IDLE and DONE.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      inv_q   <= 1'b0;
      nst_q   <= MSI_I;
    end else begin
      case (state_q)
        S_IDLE: if (ccwait) begin
          addr_q  <= snoopy_addr;
          inv_q   <= ccinv;
          state_q <= S_LOOKUP;
        end
        S_LOOKUP: begin
          if (inv_q & valid_blk) begin
            nst_q   <= MSI_I;
            state_q <= S_UPDATE;
          end else if (~inv_q & m_blk) begin
            state_q <= S_SEND0;
          end else begin
            state_q <= S_DONE;
          end
        end
        S_SEND0: if (accepted) state_q <= S_SEND1;
        S_SEND1: if (accepted) begin
          nst_q   <= MSI_S;
          state_q <= S_UPDATE;
        end
        S_UPDATE: state_q <= S_DONE;
        S_DONE:   if (!ccwait) state_q <= S_IDLE;
        default:  state_q <= S_IDLE;
      endcase
    end
  end

  // In IDLE cctrans follows ccwait directly so the bus never sees a
  // premature 1->0; reset forces the busy/hold indications low.
  assign cctrans    = (state_q == S_IDLE) ? (ccwait & ~RST) : (state_q != S_DONE);
  assign snoop_hold = ~RST & ((state_q != S_IDLE) | ccwait);

  // Lookup address: live snoop address while idle, latched copy otherwise.
  assign lk_addr = (state_q != S_IDLE) ? addr_q : (RST ? 32'h0 : snoopy_addr);

  // Data supply; outputs are pure state decodes so they hold under stall.
  assign snoop_dWEN  = sending;
  assign snoop_data  = (state_q == S_SEND0) ? lk_data0 :
                       (state_q == S_SEND1) ? lk_data1 : BAD;
  assign snoop_daddr = sending ? {addr_q[31:3], (state_q == S_SEND1), 2'b00} : BAD;

  // State write strobe.
  assign st_we    = (state_q == S_UPDATE);
  assign st_state = (state_q == S_UPDATE) ? nst_q : MSI_I;

endmodule

// File: tb/tb_snoop_responder.sv
// Directed bench for snoop_responder: each task drives one scenario and
// checks outputs cycle by cycle against hand-computed values.
module tb_snoop_responder;

  localparam logic [31:0] BAD = 32'hBAD1BAD1;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        ccwait = 1'b0, ccinv = 1'b0;
  logic [31:0] snoopy_addr = '0;
  logic        cctrans, snoop_dWEN, st_we, snoop_hold;
  logic [31:0] snoop_data, snoop_daddr, lk_addr;
  logic        snoop_dwait = 1'b0;
  logic        lk_hit = 1'b0;
  logic [1:0]  lk_state = 2'b00, st_state;
  logic [31:0] lk_data0 = '0, lk_data1 = '0;

  int n_cmp = 0;
  int n_err = 0;

  snoop_responder #(.BAD(BAD)) dut (
    .CLK(CLK), .RST(RST), .ccwait(ccwait), .ccinv(ccinv),
    .snoopy_addr(snoopy_addr), .cctrans(cctrans), .snoop_dWEN(snoop_dWEN),
    .snoop_data(snoop_data), .snoop_daddr(snoop_daddr),
    .snoop_dwait(snoop_dwait), .lk_addr(lk_addr), .lk_hit(lk_hit),
    .lk_state(lk_state), .lk_data0(lk_data0), .lk_data1(lk_data1),
    .st_we(st_we), .st_state(st_state), .snoop_hold(snoop_hold)
  );

  always #5 CLK = ~CLK;

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge CLK); #1;
  endtask

  task automatic test_reset();
    ccwait = 1'b1;  // reset must mask the combinational cctrans/hold path
    #2;
    n_cmp++; if (cctrans !== 1'b0) begin n_err++; $display("FAIL rst_cctrans got=%0b exp=0", cctrans); end
    n_cmp++; if (snoop_hold !== 1'b0) begin n_err++; $display("FAIL rst_hold got=%0b exp=0", snoop_hold); end
    n_cmp++; if (snoop_dWEN !== 1'b0 || st_we !== 1'b0 || st_state !== 2'b00)
      begin n_err++; $display("FAIL rst_strobes got=%0b%0b%0h exp=000", snoop_dWEN, st_we, st_state); end
    n_cmp++; if (snoop_data !== BAD || snoop_daddr !== BAD)
      begin n_err++; $display("FAIL rst_bad got=%h/%h exp=%h", snoop_data, snoop_daddr, BAD); end
    n_cmp++; if (lk_addr !== 32'h0) begin n_err++; $display("FAIL rst_lkaddr got=%h exp=0", lk_addr); end
    ccwait = 1'b0;
    cyc();
    RST = 1'b0;
    cyc();
    n_cmp++; if (snoop_hold !== 1'b0 || cctrans !== 1'b0)
      begin n_err++; $display("FAIL rst_idle got=%0b%0b exp=00", snoop_hold, cctrans); end
  endtask

  task automatic test_miss();
    logic exp_c [3] = '{1'b1, 1'b1, 1'b0};
    snoopy_addr = 32'h0000_1004; ccinv = 1'b0; ccwait = 1'b1; lk_hit = 1'b0; lk_state = 2'b10;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_cmp++; if (cctrans !== exp_c[c]) begin n_err++; $display("FAIL miss_cctrans c%0d got=%0b exp=%0b", c, cctrans, exp_c[c]); end
      n_cmp++; if (snoop_dWEN !== 1'b0 || st_we !== 1'b0)
        begin n_err++; $display("FAIL miss_strobes c%0d got=%0b%0b exp=00", c, snoop_dWEN, st_we); end
      if (c == 1) begin
        n_cmp++; if (lk_addr !== 32'h0000_1004) begin n_err++; $display("FAIL miss_lkaddr got=%h exp=00001004", lk_addr); end
      end
      cyc();
    end
    ccwait = 1'b0;
    cyc();
    n_cmp++; if (snoop_hold !== 1'b0) begin n_err++; $display("FAIL miss_idle_hold got=%0b exp=0", snoop_hold); end
  endtask

  task automatic test_m_read_stall();
    // cycles: 0 IDLE, 1 LOOKUP, 2-4 SEND0 (two stalls), 5 SEND1, 6 UPDATE, 7 DONE
    logic        e_wen [8] = '{0, 0, 1, 1, 1, 1, 0, 0};
    logic        e_we  [8] = '{0, 0, 0, 0, 0, 0, 1, 0};
    logic        e_ct  [8] = '{1, 1, 1, 1, 1, 1, 1, 0};
    logic        e_stl [8] = '{0, 0, 1, 1, 0, 0, 0, 0};
    logic [31:0] e_dat [8] = '{BAD, BAD, 32'h1111_1111, 32'h1111_1111, 32'h1111_1111, 32'h2222_2222, BAD, BAD};
    logic [31:0] e_da  [8] = '{BAD, BAD, 32'h0000_1000, 32'h0000_1000, 32'h0000_1000, 32'h0000_1004, BAD, BAD};
    snoopy_addr = 32'h0000_1004; ccinv = 1'b0; ccwait = 1'b1;
    lk_hit = 1'b1; lk_state = 2'b10; lk_data0 = 32'h1111_1111; lk_data1 = 32'h2222_2222;
    for (int c = 0; c < 8; c++) begin
      snoop_dwait = e_stl[c];
      #1;
      n_cmp++; if (cctrans !== e_ct[c]) begin n_err++; $display("FAIL mrd_cctrans c%0d got=%0b exp=%0b", c, cctrans, e_ct[c]); end
      n_cmp++; if (snoop_dWEN !== e_wen[c]) begin n_err++; $display("FAIL mrd_dwen c%0d got=%0b exp=%0b", c, snoop_dWEN, e_wen[c]); end
      n_cmp++; if (snoop_data !== e_dat[c] || snoop_daddr !== e_da[c])
        begin n_err++; $display("FAIL mrd_word c%0d got=%h@%h exp=%h@%h", c, snoop_data, snoop_daddr, e_dat[c], e_da[c]); end
      n_cmp++; if (st_we !== e_we[c] || st_state !== (e_we[c] ? 2'b01 : 2'b00))
        begin n_err++; $display("FAIL mrd_st c%0d got=%0b/%0h exp=%0b/%0h", c, st_we, st_state, e_we[c], e_we[c] ? 2'b01 : 2'b00); end
      cyc();
    end
    ccwait = 1'b0; snoop_dwait = 1'b0;
    cyc();
  endtask

  task automatic test_invalidate();
    logic e_ct [4] = '{1, 1, 1, 0};
    logic e_we [4] = '{0, 0, 1, 0};
    snoopy_addr = 32'h0000_2008; ccinv = 1'b1; ccwait = 1'b1; lk_hit = 1'b1; lk_state = 2'b01;
    for (int c = 0; c < 4; c++) begin
      if (c == 1) ccinv = 1'b0;  // late change must be ignored
      #1;
      n_cmp++; if (cctrans !== e_ct[c]) begin n_err++; $display("FAIL inv_cctrans c%0d got=%0b exp=%0b", c, cctrans, e_ct[c]); end
      n_cmp++; if (st_we !== e_we[c] || st_state !== 2'b00)
        begin n_err++; $display("FAIL inv_st c%0d got=%0b/%0h exp=%0b/0", c, st_we, st_state, e_we[c]); end
      n_cmp++; if (snoop_dWEN !== 1'b0) begin n_err++; $display("FAIL inv_dwen c%0d got=%0b exp=0", c, snoop_dWEN); end
      cyc();
    end
    ccwait = 1'b0;
    cyc();
  endtask

  task automatic test_s_read_hold();
    snoopy_addr = 32'h0000_3000; ccinv = 1'b0; ccwait = 1'b1; lk_hit = 1'b1; lk_state = 2'b01;
    cyc(); cyc();  // IDLE, LOOKUP
    for (int c = 2; c < 6; c++) begin
      #1;
      n_cmp++; if (cctrans !== 1'b0) begin n_err++; $display("FAIL srd_cctrans c%0d got=%0b exp=0", c, cctrans); end
      n_cmp++; if (snoop_dWEN !== 1'b0 || st_we !== 1'b0)
        begin n_err++; $display("FAIL srd_strobes c%0d got=%0b%0b exp=00", c, snoop_dWEN, st_we); end
      n_cmp++; if (snoop_hold !== 1'b1) begin n_err++; $display("FAIL srd_hold c%0d got=%0b exp=1", c, snoop_hold); end
      cyc();
    end
    ccwait = 1'b0;
    cyc();
    n_cmp++; if (snoop_hold !== 1'b0) begin n_err++; $display("FAIL srd_idle_hold got=%0b exp=0", snoop_hold); end
  endtask

  task automatic test_ccwait_drop();
    snoopy_addr = 32'h0000_4004; ccinv = 1'b0; ccwait = 1'b1; snoop_dwait = 1'b0;
    lk_hit = 1'b1; lk_state = 2'b10; lk_data0 = 32'hA0A0_0000; lk_data1 = 32'hB0B0_0001;
    cyc(); cyc();
    ccwait = 1'b0;  // dropped during SEND0
    #1;
    n_cmp++; if (snoop_dWEN !== 1'b1 || snoop_data !== 32'hA0A0_0000 || snoop_daddr !== 32'h0000_4000)
      begin n_err++; $display("FAIL drop_w0 got=%0b %h@%h exp=1 a0a00000@00004000", snoop_dWEN, snoop_data, snoop_daddr); end
    n_cmp++; if (cctrans !== 1'b1) begin n_err++; $display("FAIL drop_cctrans got=%0b exp=1", cctrans); end
    cyc();
    n_cmp++; if (snoop_dWEN !== 1'b1 || snoop_data !== 32'hB0B0_0001 || snoop_daddr !== 32'h0000_4004)
      begin n_err++; $display("FAIL drop_w1 got=%0b %h@%h exp=1 b0b00001@00004004", snoop_dWEN, snoop_data, snoop_daddr); end
    cyc();
    n_cmp++; if (st_we !== 1'b1 || st_state !== 2'b01)
      begin n_err++; $display("FAIL drop_st got=%0b/%0h exp=1/1", st_we, st_state); end
    cyc();
    n_cmp++; if (cctrans !== 1'b0 || snoop_hold !== 1'b1)
      begin n_err++; $display("FAIL drop_done got=%0b%0b exp=01", cctrans, snoop_hold); end
    cyc();
    n_cmp++; if (snoop_hold !== 1'b0) begin n_err++; $display("FAIL drop_idle_hold got=%0b exp=0", snoop_hold); end
  endtask

  task automatic test_reset_mid_send();
    snoopy_addr = 32'h0000_5000; ccinv = 1'b0; ccwait = 1'b1; snoop_dwait = 1'b0;
    lk_hit = 1'b1; lk_state = 2'b10; lk_data0 = 32'h5555_0000; lk_data1 = 32'h5555_0001;
    cyc(); cyc(); cyc();  // now in SEND1
    snoop_dwait = 1'b1;
    #1;
    n_cmp++; if (snoop_dWEN !== 1'b1 || snoop_data !== 32'h5555_0001)
      begin n_err++; $display("FAIL rms_pre got=%0b %h exp=1 55550001", snoop_dWEN, snoop_data); end
    RST = 1'b1;
    #1;
    n_cmp++; if (snoop_dWEN !== 1'b0 || cctrans !== 1'b0 || snoop_hold !== 1'b0)
      begin n_err++; $display("FAIL rms_async got=%0b%0b%0b exp=000", snoop_dWEN, cctrans, snoop_hold); end
    n_cmp++; if (snoop_data !== BAD || lk_addr !== 32'h0)
      begin n_err++; $display("FAIL rms_vals got=%h/%h exp=%h/0", snoop_data, lk_addr, BAD); end
    cyc();
    ccwait = 1'b0; snoop_dwait = 1'b0;
    RST = 1'b0;
    cyc();
    n_cmp++; if (snoop_hold !== 1'b0 || cctrans !== 1'b0 || st_we !== 1'b0)
      begin n_err++; $display("FAIL rms_idle got=%0b%0b%0b exp=000", snoop_hold, cctrans, st_we); end
  endtask

  initial begin
    test_reset();
    test_miss();
    test_m_read_stall();
    test_invalidate();
    test_s_read_hold();
    test_ccwait_drop();
    test_reset_mid_send();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule

// File: doc/snoop_responder.md
# snoop_responder

Cache-side responder for the two-cache snoopy coherence bus, one instance per dcache. It takes the snoop requests the bus controller issues to the non-master cache (`ccwait`, `ccinv`, `snoopy_addr`) and looks the address up in its cache's frame arrays. On a read-miss snoop to a Modified block it supplies the two-word block cache-to-cache; on an invalidate snoop it invalidates the block. It then updates the block's MSI state and signals completion by dropping `cctrans`.

## Interface

Parameters:
- `BAD`, 32'hBAD1BAD1, value driven on `snoop_data`/`snoop_daddr` when not supplying data

Ports:
- `CLK` in 1: clock. One clock; reset is asynchronous and active-high.
- `RST` in 1: asynchronous, active-high reset.
- `ccwait` in 1: bus snoop request to this cache; level, held by the bus until it sees `cctrans` low.
- `ccinv` in 1: qualifies `ccwait`. 1 = invalidate snoop, 0 = read-miss snoop. Ignored when `ccwait`=0.
- `snoopy_addr` in 32: snooped word address, valid while `ccwait`=1.
- `cctrans` out 1: responder busy. The bus treats 1→0 as snoop complete.
- `snoop_dWEN` out 1: supplying block data to the bus (cache_dWEN toward the bus).
- `snoop_data` out 32: word being supplied.
- `snoop_daddr` out 32: address of the word being supplied.
- `snoop_dwait` in 1: bus stall for the supplied word. A word is accepted in a cycle with `snoop_dWEN`=1 and `snoop_dwait`=0.
- `lk_addr` out 32: lookup address to the frame arrays (latched snoop address).
- `lk_hit` in 1: combinational hit for `lk_addr`.
- `lk_state` in 2: MSI state of the hit frame. I=00, S=01, M=10; 11 is treated as I.
- `lk_data0`, `lk_data1` in 32 each: block words 0 and 1 of the hit frame.
- `st_we` out 1: one-cycle write strobe for the frame state.
- `st_state` out 2: new state written at `lk_addr` when `st_we`=1.
- `snoop_hold` out 1: tells the owning cache FSM not to modify its arrays this cycle.

## Operation

- Address: word-aligned, 2-word blocks, block offset is bit 2.
  - `snoop_daddr` = {addr[31:3], w, 2'b00}, where w is the word index being sent.
- `addr_q` latches `snoopy_addr` on the IDLE cycle where `ccwait`=1. `lk_addr`=`addr_q` in all states except IDLE.
- `inv_q` latches `ccinv` in the same cycle.
- States:
  - IDLE:
    - `cctrans`=`ccwait` (combinational, so the bus never sees a false "done").
    - `ccwait`=1 → LOOKUP.
  - LOOKUP: `cctrans`=1. Decision uses this cycle's `lk_hit`/`lk_state`:
    - `inv_q` & hit & state∈{S,M} → UPDATE with `st_state`=I.
    - ~`inv_q` & hit & M → SEND0.
    - Otherwise (miss, I, 11, or read-snoop hit in S) → DONE, no state change.
  - SEND0: `cctrans`=1, `snoop_dWEN`=1, `snoop_data`=`lk_data0`, w=0. Accepted → SEND1.
  - SEND1: same with `lk_data1`, w=1. Accepted → UPDATE with `st_state`=S (M→S downgrade).
  - UPDATE: `cctrans`=1, `st_we`=1 for exactly this cycle → DONE.
  - DONE: `cctrans`=0. `ccwait`=0 → IDLE; otherwise stay. A new snoop is not started until `ccwait` has dropped.
- `snoop_hold` = (state≠IDLE) | `ccwait`.
- `ccwait` falling mid-transaction (LOOKUP..UPDATE) is ignored: the sequence completes, then DONE→IDLE.
- `ccinv` changing after the IDLE sample is ignored (uses `inv_q`).
- Outside SEND0/SEND1: `snoop_dWEN`=0 and `snoop_data`/`snoop_daddr`=`BAD`.
- Outside UPDATE: `st_we`=0 and `st_state`=00.

## Timing

- Reset (async, any state, including mid-SEND): state=IDLE, `addr_q`=0, `inv_q`=0.
  - While `RST`=1: `cctrans`, `snoop_dWEN`, `st_we`, `snoop_hold` are 0; `snoop_data`/`snoop_daddr`=`BAD`; `lk_addr`=0; `st_state`=00.
- Miss or S read-snoop: `cctrans` high for 2 cycles (IDLE-with-`ccwait`, LOOKUP), low from cycle 2.
- Invalidate hit: `cctrans` high for 3 cycles; `st_we` in cycle 2.
- M read-snoop, `snoop_dwait`=0 throughout:
  - word0 in cycle 2, word1 in cycle 3, `st_we` in cycle 4, `cctrans` low in cycle 5.
  - Each stall cycle extends the sequence by one cycle.
- `snoop_data`, `snoop_daddr` and `snoop_dWEN` are held stable while `snoop_dwait`=1.

## Test plan

- Reset mid-SEND1 with `snoop_dwait`=1: assert `RST` → same cycle `snoop_dWEN`=0, `cctrans`=0 while `RST`=1; after release, state is IDLE.
- Read snoop 0x0000_1004, miss: `cctrans` 1,1,0 over cycles 0–2; no `snoop_dWEN`, no `st_we`.
- Read snoop 0x0000_1004, hit M, `lk_data0`=0x1111_1111, `lk_data1`=0x2222_2222, `snoop_dwait`=1 for 2 cycles then 0:
  - word0 0x1111_1111 @0x0000_1000 held 3 cycles.
  - word1 0x2222_2222 @0x0000_1004.
  - `st_we` with `st_state`=01; then `cctrans`=0.
- Invalidate snoop 0x0000_2008, hit S: `st_we`=1 with `st_state`=00 in cycle 2; `cctrans`=0 in cycle 3; `snoop_dWEN` never 1.
- Read snoop, hit S: no data, no `st_we`, `cctrans` low in cycle 2; stays in DONE with `ccwait`=1 held for 4 cycles; no second lookup until `ccwait` drops.
- `ccwait` dropped during SEND0 of an M hit: both words still sent and the state written S; returns to IDLE; `snoop_hold`=0 the cycle after.
